// File: rtl/sram_responder.sv
// Word-addressed SRAM responder with byte-lane writes, READ_LAT-stage read pipeline and out-of-window error tracking.
// Optional cycle counter at CNT_ADDR is enabled by defining SRAM_RESP_CYCLE_CNT_EN.
module sram_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          READ_LAT  = 1,
  parameter logic [31:0] CNT_ADDR  = 32'h1FAF_E000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] err_cnt,
  output logic [31:0] err_addr
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]                mem [DEPTH];
  logic [READ_LAT-1:0]        vld_pipe;
  logic [READ_LAT-1:0][31:0]  dat_pipe;
  logic [ADDR_W-1:0]          idx;
  logic                       hit, cnt_sel, rd_acc, wr_acc, err_acc;
  logic [31:0]                rd_val;
  logic [1:0]                 addr_unused;

  assign addr_unused = sram_addr[1:0];
  assign idx         = sram_addr[ADDR_W+1:2];
  assign hit         = (sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);

`ifdef SRAM_RESP_CYCLE_CNT_EN
  logic [31:0] cyc_cnt;

  assign cnt_sel = (sram_addr[31:2] == CNT_ADDR[31:2]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      cyc_cnt <= '0;
    else if (sram_en && cnt_sel && sram_wen == 4'hF)
      cyc_cnt <= sram_wdata;
    else
      cyc_cnt <= cyc_cnt + 32'd1;
  end

  // A counter read returns the value the counter takes on the accepting edge.
  always_comb begin
    rd_val = '0;
    if (cnt_sel)  rd_val = cyc_cnt + 32'd1;
    else if (hit) rd_val = mem[idx];
  end
`else
  assign cnt_sel = 1'b0;
  assign rd_val  = hit ? mem[idx] : 32'h0;
`endif

  assign rd_acc  = sram_en && (sram_wen == 4'h0);
  assign wr_acc  = sram_en && (sram_wen != 4'h0) && hit && !cnt_sel;
  assign err_acc = sram_en && !hit && !cnt_sel;

  // Storage and read-data pipeline carry no reset; only the valid bits do.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (wr_acc && sram_wen[i]) mem[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
    dat_pipe[0] <= rd_val;
    for (int i = 1; i < READ_LAT; i++)
      dat_pipe[i] <= dat_pipe[i-1];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe   <= '0;
      sram_rdata <= '0;
    end else begin
      vld_pipe[0] <= rd_acc;
      for (int i = 1; i < READ_LAT; i++)
        vld_pipe[i] <= vld_pipe[i-1];
      if (vld_pipe[READ_LAT-1]) sram_rdata <= dat_pipe[READ_LAT-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_cnt  <= '0;
      err_addr <= '0;
    end else if (err_acc) begin
      err_addr <= sram_addr;
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_sram_responder.sv
// Randomized scoreboard bench for sram_responder: three instances (READ_LAT 1..3) share stimulus;
// a reference model queues expected read results and error updates, a negedge monitor checks them.
module tb_sram_responder;
  localparam int NL = 3;

  logic        clk = 1'b0, resetn = 1'b1, sram_en = 1'b0;
  logic [3:0]  sram_wen = '0;
  logic [31:0] sram_addr = '0, sram_wdata = '0;
  logic [31:0] rdata [NL];
  logic [15:0] ecnt  [NL];
  logic [31:0] eaddr [NL];

  for (genvar g = 0; g < NL; g++) begin : g_dut
    sram_responder #(.ADDR_W(12), .BASE_ADDR(32'h0), .READ_LAT(g + 1)) u_dut (
      .clk(clk), .resetn(resetn), .sram_en(sram_en), .sram_wen(sram_wen),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(rdata[g]),
      .err_cnt(ecnt[g]), .err_addr(eaddr[g]));
  end

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0, bad = 0;
  bit armed = 0;

  typedef struct { int due; logic [31:0] val; } ev_t;
  ev_t         rq [NL][$];
  ev_t         eq [$];
  logic [31:0] mem_m [int];
  logic [31:0] exp_rd [NL];
  logic [15:0] exp_ec = '0;
  logic [31:0] exp_ea = '0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: retire due events into expected outputs, then compare every output.
  always @(negedge clk) if (armed) begin
    while (eq.size() > 0 && eq[0].due <= cyc) begin
      exp_ea = eq[0].val;
      if (exp_ec != 16'hFFFF) exp_ec = exp_ec + 16'd1;
      void'(eq.pop_front());
    end
    for (int g = 0; g < NL; g++) begin
      while (rq[g].size() > 0 && rq[g][0].due <= cyc) begin
        exp_rd[g] = rq[g][0].val;
        void'(rq[g].pop_front());
      end
      check($sformatf("rdata_L%0d", g + 1), rdata[g], exp_rd[g]);
      check($sformatf("err_cnt_L%0d", g + 1), {16'h0, ecnt[g]}, {16'h0, exp_ec});
      check($sformatf("err_addr_L%0d", g + 1), eaddr[g], exp_ea);
    end
  end

  // Issue one access at the next edge and record its expected effects.
  task automatic issue(bit en, logic [3:0] wen, logic [31:0] addr, logic [31:0] wd);
    int a;
    bit hit;
    int idx;
    logic [31:0] w;
    a   = cyc + 1;
    hit = (addr[31:14] == 18'd0);
    idx = int'(addr[13:2]);
    if (en) begin
      if (!hit) eq.push_back('{a, addr});
      if (wen != 4'h0 && hit) begin
        w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (wen[b]) w[8*b +: 8] = wd[8*b +: 8];
        mem_m[idx] = w;
      end
      if (wen == 4'h0)
        for (int g = 0; g < NL; g++)
          rq[g].push_back('{a + g + 1, hit ? mem_m[idx] : 32'h0});
    end
    sram_en = en; sram_wen = wen; sram_addr = addr; sram_wdata = wd;
    @(posedge clk); #1;
    sram_en = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(int n);
    resetn = 1'b0;
    for (int g = 0; g < NL; g++) begin rq[g].delete(); exp_rd[g] = '0; end
    eq.delete(); exp_ec = '0; exp_ea = '0;
    repeat (n) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    int r, k;
    for (int g = 0; g < NL; g++) exp_rd[g] = '0;
    #2 resetn = 1'b0;
    armed = 1;
    @(posedge clk); #1;
    do_reset(3);
    idle(5);

    for (int i = 0; i < 16; i++) issue(1, 4'hF, 32'(i * 4), 32'(i * 4 + 1));

    issue(1, 4'hF, 32'h10, 32'h1122_3344);
    issue(1, 4'b0101, 32'h10, 32'hAABB_CCDD);
    issue(1, 4'h0, 32'h10, 32'h0);
    idle(1);
    check("byte_lane_merge", rdata[0], 32'h11BB_33DD);

    issue(1, 4'h0, 32'h0, 32'h0);
    issue(1, 4'h0, 32'h4, 32'h0);
    issue(1, 4'h0, 32'h8, 32'h0);
    idle(3);
    check("stream_last_L3", rdata[2], 32'd9);
    idle(2);
    check("stream_hold_L3", rdata[2], 32'd9);

    issue(1, 4'h0, 32'h0000_4000, 32'h0);
    check("oow_cnt1", {16'h0, ecnt[0]}, 32'd1);
    check("oow_addr1", eaddr[0], 32'h0000_4000);
    issue(1, 4'hF, 32'h0000_4004, 32'hDEAD_BEEF);
    check("oow_cnt2", {16'h0, ecnt[0]}, 32'd2);
    check("oow_rdata_L1", rdata[0], 32'h0);
    issue(1, 4'h0, 32'h4, 32'h0);
    idle(3);
    check("oow_write_dropped", rdata[2], 32'd5);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 15);
      case (r)
        0:       issue(1, 4'h0, 32'h4000 | ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3)), 32'h0);
        1:       issue(1, 4'($urandom), 32'h8000 | $urandom, $urandom);
        2, 3, 4: issue(1, 4'($urandom), 32'(k * 4) | 32'($urandom_range(0, 3)), $urandom);
        5:       issue(0, 4'($urandom), 32'(k * 4), $urandom);
        default: issue(1, 4'h0, 32'(k * 4) | 32'($urandom_range(0, 3)), 32'h0);
      endcase
    end
    idle(4);

    issue(1, 4'hF, 32'h14, 32'hCAFE_F00D);
    issue(1, 4'h0, 32'h14, 32'h0);
    do_reset(3);
    idle(8);
    check("after_reset_rdata_L2", rdata[1], 32'h0);

    for (int i = 0; i < 65540; i++) issue(1, 4'h0, 32'hF000_0000 | 32'(i * 4), 32'h0);
    idle(2);
    check("err_cnt_saturated", {16'h0, ecnt[0]}, 32'h0000_FFFF);

    armed = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
